// File: rtl/snake_step_engine.sv
// Snake game engine: body shift register, direction latch, wall/self
// collision detection, scoring and LFSR-driven food placement.
module snake_step_engine #(
    parameter int          COORD_W   = 4,
    parameter int          MAX_LEN   = 16,
    parameter int          WRAP      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                              slw_clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              step_en,
    input  logic                              up,
    input  logic                              down,
    input  logic                              left,
    input  logic                              right,
    output logic [MAX_LEN*2*COORD_W-1:0]      snake,
    output logic [$clog2(MAX_LEN+1)-1:0]      length,
    output logic [COORD_W-1:0]                xfood,
    output logic [COORD_W-1:0]                yfood,
    output logic [7:0]                        score,
    output logic                              running,
    output logic                              game_over
);
    localparam int SW = 2 * COORD_W;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] L_MAX = LW'(MAX_LEN);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PLACE, S_OVER} state_t;

    function automatic logic [MAX_LEN-1:0][SW-1:0] seg_init();
        logic [MAX_LEN-1:0][SW-1:0] s;
        s    = '0;
        s[0] = {COORD_W'(2), COORD_W'(1)};
        s[1] = {COORD_W'(1), COORD_W'(1)};
        s[2] = {COORD_W'(0), COORD_W'(1)};
        return s;
    endfunction

    localparam logic [MAX_LEN-1:0][SW-1:0] SEG_INIT = seg_init();

    state_t                     r_state;
    logic [MAX_LEN-1:0][SW-1:0] r_seg;
    logic [LW-1:0]              r_len;
    logic [1:0]                 r_dir;
    logic [1:0]                 r_last;
    logic [COORD_W-1:0]         r_xfood;
    logic [COORD_W-1:0]         r_yfood;
    logic [7:0]                 r_score;
    logic [15:0]                r_lfsr;
    logic                       r_running;
    logic                       r_game_over;

    logic [1:0]                 w_req;
    logic                       w_req_vld;
    logic [COORD_W-1:0]         w_hx;
    logic [COORD_W-1:0]         w_hy;
    logic [COORD_W-1:0]         w_cx;
    logic [COORD_W-1:0]         w_cy;
    logic                       w_wall;
    logic [SW-1:0]              w_cand;
    logic [SW-1:0]              w_pcand;
    logic                       w_grow;
    logic [LW-1:0]              w_lim;
    logic                       w_hit;
    logic                       w_pocc;
    logic                       w_fb;
    logic [MAX_LEN-1:0][SW-1:0] w_next;

    assign w_hx    = r_seg[0][SW-1:COORD_W];
    assign w_hy    = r_seg[0][COORD_W-1:0];
    assign w_cand  = {w_cx, w_cy};
    assign w_pcand = r_lfsr[SW-1:0];
    assign w_grow  = (w_cand == {r_xfood, r_yfood});
    assign w_lim   = (w_grow && r_len < L_MAX) ? r_len : r_len - LW'(1);
    assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_req     = r_dir;
        w_req_vld = 1'b1;
        if (up)         w_req = D_UP;
        else if (down)  w_req = D_DOWN;
        else if (left)  w_req = D_LEFT;
        else if (right) w_req = D_RIGHT;
        else            w_req_vld = 1'b0;
    end

    always_comb begin
        w_cx   = w_hx;
        w_cy   = w_hy;
        w_wall = 1'b0;
        case (r_dir)
            D_UP: begin
                w_cy   = w_hy - COORD_W'(1);
                w_wall = (w_hy == '0);
            end
            D_DOWN: begin
                w_cy   = w_hy + COORD_W'(1);
                w_wall = (w_hy == '1);
            end
            D_LEFT: begin
                w_cx   = w_hx - COORD_W'(1);
                w_wall = (w_hx == '0);
            end
            default: begin
                w_cx   = w_hx + COORD_W'(1);
                w_wall = (w_hx == '1);
            end
        endcase
        if (WRAP != 0) w_wall = 1'b0;
    end

    // Tail segment is excluded from the self-hit set since it moves away
    always_comb begin
        w_hit  = 1'b0;
        w_pocc = 1'b0;
        w_next = {r_seg[MAX_LEN-2:0], w_cand};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < w_lim && r_seg[i] == w_cand) w_hit = 1'b1;
            if (LW'(i) < r_len && r_seg[i] == w_pcand) w_pocc = 1'b1;
            if (!w_grow && LW'(i) == r_len) w_next[i] = '0;
        end
    end

    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_seg       <= SEG_INIT;
            r_len       <= LW'(3);
            r_dir       <= D_RIGHT;
            r_last      <= D_RIGHT;
            r_xfood     <= COORD_W'(3);
            r_yfood     <= COORD_W'(3);
            r_score     <= '0;
            r_lfsr      <= LFSR_SEED;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            if (w_req_vld && (w_req ^ 2'b01) != r_last) r_dir <= w_req;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (step_en) begin
                        if (w_wall || w_hit) begin
                            r_state     <= S_OVER;
                            r_running   <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_seg  <= w_next;
                            r_last <= r_dir;
                            if (w_grow) begin
                                if (r_len < L_MAX) r_len <= r_len + LW'(1);
                                if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                                r_state <= S_PLACE;
                            end
                        end
                    end
                end
                S_PLACE: begin
                    if (!w_pocc) begin
                        r_xfood <= w_pcand[SW-1:COORD_W];
                        r_yfood <= w_pcand[COORD_W-1:0];
                        r_state <= S_RUN;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        r_seg       <= SEG_INIT;
                        r_len       <= LW'(3);
                        r_dir       <= D_RIGHT;
                        r_last      <= D_RIGHT;
                        r_xfood     <= COORD_W'(3);
                        r_yfood     <= COORD_W'(3);
                        r_score     <= '0;
                        r_state     <= S_RUN;
                        r_running   <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snake     = r_seg;
    assign length    = r_len;
    assign xfood     = r_xfood;
    assign yfood     = r_yfood;
    assign score     = r_score;
    assign running   = r_running;
    assign game_over = r_game_over;
endmodule

// File: tb/tb_snake_step_engine.sv
// Directed bench for snake_step_engine: moves, growth, walls (both wrap
// modes), self hit, restart and asynchronous reset during food placement.
module tb_snake_step_engine;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         step_en = 1'b0;
    logic         up = 1'b0;
    logic         down = 1'b0;
    logic         left = 1'b0;
    logic         right = 1'b0;
    logic [127:0] snake, snake_w;
    logic [4:0]   length, length_w;
    logic [3:0]   xfood, yfood, xfood_w, yfood_w;
    logic [7:0]   score, score_w;
    logic         running, running_w;
    logic         game_over, game_over_w;
    logic [15:0]  m_lfsr;
    int           total = 0;
    int           bad = 0;

    localparam logic [127:0] SNAKE0 = 128'h011121;

    snake_step_engine #(.WRAP(0)) dut (
        .slw_clk(clk), .reset(rst_n), .start(start), .step_en(step_en),
        .up(up), .down(down), .left(left), .right(right),
        .snake(snake), .length(length), .xfood(xfood), .yfood(yfood),
        .score(score), .running(running), .game_over(game_over)
    );

    snake_step_engine #(.WRAP(1)) dut_w (
        .slw_clk(clk), .reset(rst_n), .start(start), .step_en(step_en),
        .up(up), .down(down), .left(left), .right(right),
        .snake(snake_w), .length(length_w), .xfood(xfood_w), .yfood(yfood_w),
        .score(score_w), .running(running_w), .game_over(game_over_w)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= nxt(m_lfsr);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic step1();
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
    endtask

    task automatic press(input int d);
        up    = (d == 0);
        down  = (d == 1);
        left  = (d == 2);
        right = (d == 3);
        tick();
        {up, down, left, right} = 4'b0;
    endtask

    task automatic wait_lfsr(input logic [7:0] v);
        logic [15:0] t;
        int n;
        n = 0;
        t = nxt(m_lfsr);
        while (t[7:0] != v && n < 20000) begin
            tick();
            t = nxt(m_lfsr);
            n++;
        end
        total++;
        if (t[7:0] != v) begin
            bad++;
            $display("FAIL lfsr_wait got=%h exp=%h", t[7:0], v);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (snake !== SNAKE0) begin bad++; $display("FAIL rst_snake got=%h exp=%h", snake, SNAKE0); end
        total++; if (length !== 5'd3) begin bad++; $display("FAIL rst_len got=%0d exp=3", length); end
        total++; if ({xfood, yfood} !== 8'h33) begin bad++; $display("FAIL rst_food got=%h exp=33", {xfood, yfood}); end
        total++; if (score !== 8'd0) begin bad++; $display("FAIL rst_score got=%0d exp=0", score); end
        total++; if ({running, game_over} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {running, game_over}); end
        step1();
        total++; if (snake !== SNAKE0) begin bad++; $display("FAIL idle_step got=%h exp=%h", snake, SNAKE0); end
    endtask

    task automatic test_step();
        do_start();
        step1();
        total++; if (snake !== 128'h112131) begin bad++; $display("FAIL step_snake got=%h exp=112131", snake); end
        total++; if (length !== 5'd3) begin bad++; $display("FAIL step_len got=%0d exp=3", length); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL step_run got=%b exp=1", running); end
    endtask

    task automatic test_reverse();
        do_reset();
        do_start();
        press(2);
        step1();
        total++; if (snake[7:0] !== 8'h31) begin bad++; $display("FAIL rev_head got=%h exp=31", snake[7:0]); end
        step1();
        total++; if (snake !== 128'h213141) begin bad++; $display("FAIL rev_snake got=%h exp=213141", snake); end
    endtask

    task automatic test_grow();
        logic [7:0] c, exp_f;
        logic found;
        do_reset();
        do_start();
        press(1);
        step1();
        step1();
        total++; if (snake !== 128'h212223) begin bad++; $display("FAIL grow_down got=%h exp=212223", snake); end
        press(3);
        step1();
        total++; if (snake !== 128'h21222333) begin bad++; $display("FAIL grow_snake got=%h exp=21222333", snake); end
        total++; if (length !== 5'd4) begin bad++; $display("FAIL grow_len got=%0d exp=4", length); end
        total++; if (score !== 8'd1) begin bad++; $display("FAIL grow_score got=%0d exp=1", score); end
        step_en = 1'b1;
        found = 1'b0;
        exp_f = 8'h00;
        for (int k = 0; k < 256 && !found; k++) begin
            c = m_lfsr[7:0];
            found = (c != 8'h33 && c != 8'h23 && c != 8'h22 && c != 8'h21);
            if (found) exp_f = c;
            tick();
            step_en = 1'b0;
        end
        total++; if (!found) begin bad++; $display("FAIL place_found got=0 exp=1"); end
        total++; if ({xfood, yfood} !== exp_f) begin bad++; $display("FAIL place_food got=%h exp=%h", {xfood, yfood}, exp_f); end
        total++; if (snake !== 128'h21222333) begin bad++; $display("FAIL place_drop got=%h exp=21222333", snake); end
        step1();
        total++; if (snake[15:0] !== 16'h3343) begin bad++; $display("FAIL after_place got=%h exp=3343", snake[15:0]); end
    endtask

    task automatic test_wall();
        do_reset();
        do_start();
        press(0);
        step1();
        total++; if (snake[7:0] !== 8'h20) begin bad++; $display("FAIL wall_pre got=%h exp=20", snake[7:0]); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL wall_pre_over got=%b exp=0", game_over); end
        step1();
        total++; if (snake !== 128'h112120) begin bad++; $display("FAIL wall_body got=%h exp=112120", snake); end
        total++; if ({running, game_over} !== 2'b01) begin bad++; $display("FAIL wall_flags got=%b exp=01", {running, game_over}); end
        total++; if (snake_w !== 128'h21202F) begin bad++; $display("FAIL wrap_body got=%h exp=21202f", snake_w); end
        total++; if (game_over_w !== 1'b0) begin bad++; $display("FAIL wrap_over got=%b exp=0", game_over_w); end
    endtask

    task automatic test_self_hit();
        do_reset();
        do_start();
        press(1);
        step1();
        step1();
        press(3);
        wait_lfsr(8'h43);
        step1();
        tick();
        total++; if ({xfood, yfood} !== 8'h43) begin bad++; $display("FAIL sh_food1 got=%h exp=43", {xfood, yfood}); end
        wait_lfsr(8'hCC);
        step1();
        total++; if (snake !== 128'h2122233343) begin bad++; $display("FAIL sh_len5 got=%h exp=2122233343", snake); end
        total++; if ({length, score} !== {5'd5, 8'd2}) begin bad++; $display("FAIL sh_cnt got=%0d/%0d exp=5/2", length, score); end
        tick();
        total++; if ({xfood, yfood} !== 8'hCC) begin bad++; $display("FAIL sh_food2 got=%h exp=cc", {xfood, yfood}); end
        press(0);
        step1();
        total++; if (snake !== 128'h2223334342) begin bad++; $display("FAIL sh_up got=%h exp=2223334342", snake); end
        press(2);
        step1();
        press(1);
        step1();
        total++; if (snake !== 128'h2333434232) begin bad++; $display("FAIL sh_body got=%h exp=2333434232", snake); end
        total++; if ({running, game_over} !== 2'b01) begin bad++; $display("FAIL sh_flags got=%b exp=01", {running, game_over}); end
        start = 1'b1;
        step_en = 1'b1;
        tick();
        {start, step_en} = 2'b00;
        total++; if (snake !== SNAKE0) begin bad++; $display("FAIL restart_snake got=%h exp=%h", snake, SNAKE0); end
        total++; if ({length, score} !== {5'd3, 8'd0}) begin bad++; $display("FAIL restart_cnt got=%0d/%0d exp=3/0", length, score); end
        total++; if ({xfood, yfood} !== 8'h33) begin bad++; $display("FAIL restart_food got=%h exp=33", {xfood, yfood}); end
        total++; if ({running, game_over} !== 2'b10) begin bad++; $display("FAIL restart_flags got=%b exp=10", {running, game_over}); end
    endtask

    task automatic test_reset_place();
        do_reset();
        do_start();
        press(1);
        step1();
        step1();
        press(3);
        step1();
        rst_n = 1'b0;
        #1;
        total++; if (snake !== SNAKE0) begin bad++; $display("FAIL arst_snake got=%h exp=%h", snake, SNAKE0); end
        total++; if ({length, score} !== {5'd3, 8'd0}) begin bad++; $display("FAIL arst_cnt got=%0d/%0d exp=3/0", length, score); end
        total++; if ({running, game_over} !== 2'b00) begin bad++; $display("FAIL arst_flags got=%b exp=00", {running, game_over}); end
        tick();
        rst_n = 1'b1;
        step1();
        tick();
        total++; if ({running, snake} !== {1'b0, SNAKE0}) begin bad++; $display("FAIL arst_hold got=%b/%h exp=0/%h", running, snake, SNAKE0); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_reverse();
        test_grow();
        test_wall();
        test_self_hit();
        test_reset_place();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
